// File: rtl/pwl_logit_7.sv
// pwl_logit_7: 7-segment piecewise-linear logit (inverse of the PWL sigmoid).
// Maps a signed Q8.8 probability y_in to a signed Q8.8 logit x_out.
// Three-stage pipeline: segment select, multiply, shift/clamp.
// All stages advance together under a global enable. Bubbles are not collapsed.
// Optional macro PWL_LOGIT_RND_EN: round half up before the final shift.
// When the macro is undefined, the final shift floors.
module pwl_logit_7 #(
  parameter int X_SAT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] x_out,
  output logic        sat_out
);

  localparam logic signed [31:0] XS_POS = 32'(X_SAT);
  localparam logic signed [31:0] XS_NEG = -XS_POS;

  logic en;
  logic v1, v2, v3;

  // Stage 1 registers.
  logic        s1_sat, s1_sign;
  logic [7:0]  s1_b;
  logic [12:0] s1_k;
  logic [15:0] s1_y;

  // Stage 2 registers.
  logic        s2_sat, s2_sign;
  logic [31:0] s2_p;

  // Stage 1 combinational results.
  logic signed [15:0] ys;
  logic        sel_sat, sel_sign;
  logic [7:0]  sel_b;
  logic [12:0] sel_k;

  // Stage 2 combinational results.
  logic signed [16:0] d;
  logic [31:0] prod;

  // Stage 3 combinational results.
  logic signed [31:0] pr, sh;
  logic [15:0] x_d;
  logic        sat_d;

  assign en        = !v3 || out_ready;
  assign in_ready  = en;
  assign out_valid = v3;
  assign ys        = y_in;

  // Segment select: signed compares on the incoming probability.
  always_comb begin
    sel_sat  = 1'b0;
    sel_sign = 1'b0;
    sel_b    = '0;
    sel_k    = '0;
    if (ys < 16'sd5) begin
      sel_sat  = 1'b1;
      sel_sign = 1'b1;
    end else if (ys < 16'sd30) begin
      sel_b = 8'd57;
      sel_k = 13'd5041;
    end else if (ys < 16'sd69) begin
      sel_b = 8'd108;
      sel_k = 13'd1680;
    end else if (ys < 16'sd187) begin
      sel_b = 8'd128;
      sel_k = 13'd1111;
    end else if (ys < 16'sd226) begin
      sel_b = 8'd148;
      sel_k = 13'd1680;
    end else if (ys < 16'sd251) begin
      sel_b = 8'd199;
      sel_k = 13'd5041;
    end else begin
      sel_sat = 1'b1;
    end
  end

  // Valid pipeline: all stages advance together when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Stage 1: register the selected segment and the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sat  <= 1'b0;
      s1_sign <= 1'b0;
      s1_b    <= '0;
      s1_k    <= '0;
      s1_y    <= '0;
    end else if (en) begin
      s1_sat  <= sel_sat;
      s1_sign <= sel_sign;
      s1_b    <= sel_b;
      s1_k    <= sel_k;
      s1_y    <= y_in;
    end
  end

  // Offset from the segment breakpoint, scaled by the inverse slope.
  // The multiply is done on sign-extended operands; the low 32 bits are the
  // signed product regardless of operand signedness.
  always_comb begin
    d    = $signed({s1_y[15], s1_y}) - $signed({9'b0, s1_b});
    prod = {{15{d[16]}}, d} * {19'b0, s1_k};
  end

  // Stage 2: register the product and pass the saturation flags along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sat  <= 1'b0;
      s2_sign <= 1'b0;
      s2_p    <= '0;
    end else if (en) begin
      s2_sat  <= s1_sat;
      s2_sign <= s1_sign;
      s2_p    <= prod;
    end
  end

  // Shift back to Q8.8, clamp, and substitute the saturation value.
  always_comb begin
`ifdef PWL_LOGIT_RND_EN
    pr = $signed(s2_p) + 32'sd128;
`else
    pr = $signed(s2_p);
`endif
    sh    = pr >>> 8;
    sat_d = 1'b0;
    x_d   = sh[15:0];
    if (s2_sat) begin
      sat_d = 1'b1;
      x_d   = s2_sign ? XS_NEG[15:0] : XS_POS[15:0];
    end else if (sh > XS_POS) begin
      sat_d = 1'b1;
      x_d   = XS_POS[15:0];
    end else if (sh < XS_NEG) begin
      sat_d = 1'b1;
      x_d   = XS_NEG[15:0];
    end
  end

  // Stage 3: registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out   <= '0;
      sat_out <= 1'b0;
    end else if (en) begin
      x_out   <= x_d;
      sat_out <= sat_d;
    end
  end

endmodule
